// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the I2C register-level transaction sequencer.
package i2c_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CHECK,
        S_STOP,
        S_STOP_WAIT,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK,
        ERR_ADDR_NACK,
        ERR_DATA_NACK,
        ERR_TIMEOUT
    } err_t;

    localparam int MAX_LEN = 4;

    // Lengths above MAX_LEN are treated as MAX_LEN.
    function automatic logic [2:0] clamp_len(input logic [2:0] len);
        return (len > 3'(MAX_LEN)) ? 3'(MAX_LEN) : len;
    endfunction

endpackage

// File: rtl/i2c_reg_seq.sv
// I2C register-level transaction sequencer.
// Turns one command (device, register, 0-4 bytes, read/write) into the
// start/byte/stop handshakes of the byte-level I2C driver.
// Optional per-operation watchdog: define I2C_SEQ_TIMEOUT_EN.
module i2c_reg_seq
    import i2c_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65535
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_read,
    input  logic [6:0]  cmd_dev,
    input  logic [7:0]  cmd_reg,
    input  logic [2:0]  cmd_len,
    input  logic [31:0] cmd_wdata,
    output logic        done,
    output logic [1:0]  err,
    output logic [31:0] rdata,
    output logic        i2c_cnd_start,
    output logic        i2c_cnd_stop,
    output logic        i2c_rw,
    output logic [7:0]  i2c_tx_data,
    output logic        i2c_tx_start,
    output logic        i2c_tx_ack,
    input  logic        i2c_tx_ready,
    input  logic [7:0]  i2c_rx_data,
    input  logic        i2c_rx_ack
);

    state_t      state;
    err_t        err_q;
    logic        phase_q;   // 0: write / read phase A, 1: read phase B
    logic [2:0]  idx_q;     // byte index within the current phase, 0 = address byte
    logic        rd_q;
    logic [6:0]  dev_q;
    logic [7:0]  reg_q;
    logic [2:0]  len_q;
    logic [31:0] wdata_q;
    logic        ack_q;

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] to_cnt;
`endif

    logic [2:0]  last_idx;
    logic        write_dir;
    logic        nb_ph;
    logic [2:0]  nb_idx;
    logic        nb_rw;
    logic        nb_ack;
    logic        go_phase_b;

    assign err = err_q;

    // Payload of byte n of a phase: address, register pointer, write data, or don't-care for reads.
    function automatic logic [7:0] byte_for(input logic ph, input logic [2:0] n);
        logic [2:0] k;
        k = n - 3'd2;
        if (n == 3'd0)      return {dev_q, ph};
        else if (ph)        return 8'h00;
        else if (n == 3'd1) return reg_q;
        else                return wdata_q[{k[1:0], 3'b000} +: 8];
    endfunction

    // Sequencing decode: last byte of the phase, byte direction, and the next byte to issue.
    always_comb begin
        last_idx   = phase_q ? len_q : (rd_q ? 3'd1 : 3'd1 + len_q);
        write_dir  = !(phase_q && (idx_q != 3'd0));
        nb_ph      = (state == S_STOP_WAIT) ? 1'b1 : phase_q;
        nb_idx     = (state == S_STOP_WAIT) ? 3'd0 : idx_q + 3'd1;
        nb_rw      = nb_ph && (nb_idx != 3'd0);
        nb_ack     = !nb_rw || (nb_idx == len_q);
        go_phase_b = rd_q && !phase_q && (len_q != 3'd0) && (err_q == ERR_OK);
    end

    // Transaction FSM with registered driver handshakes, status and read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            err_q         <= ERR_OK;
            phase_q       <= 1'b0;
            idx_q         <= 3'd0;
            rd_q          <= 1'b0;
            dev_q         <= 7'd0;
            reg_q         <= 8'd0;
            len_q         <= 3'd0;
            wdata_q       <= 32'd0;
            ack_q         <= 1'b0;
            cmd_ready     <= 1'b1;
            done          <= 1'b0;
            rdata         <= 32'd0;
            i2c_cnd_start <= 1'b0;
            i2c_cnd_stop  <= 1'b0;
            i2c_rw        <= 1'b0;
            i2c_tx_data   <= 8'd0;
            i2c_tx_start  <= 1'b0;
            i2c_tx_ack    <= 1'b1;
`ifdef I2C_SEQ_TIMEOUT_EN
            to_cnt        <= 16'd0;
`endif
        end else begin
            i2c_tx_start  <= 1'b0;
            i2c_cnd_start <= 1'b0;
            i2c_cnd_stop  <= 1'b0;
            done          <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        rd_q          <= cmd_read;
                        dev_q         <= cmd_dev;
                        reg_q         <= cmd_reg;
                        len_q         <= clamp_len(cmd_len);
                        wdata_q       <= cmd_wdata;
                        rdata         <= 32'd0;
                        err_q         <= ERR_OK;
                        cmd_ready     <= 1'b0;
                        phase_q       <= 1'b0;
                        idx_q         <= 3'd0;
                        i2c_tx_start  <= 1'b1;
                        i2c_cnd_start <= 1'b1;
                        i2c_tx_data   <= {cmd_dev, 1'b0};
                        i2c_rw        <= 1'b0;
                        i2c_tx_ack    <= 1'b1;
                        state         <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
`ifdef I2C_SEQ_TIMEOUT_EN
                    to_cnt <= 16'd0;
`endif
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (i2c_tx_ready) begin
                        ack_q <= i2c_rx_ack;
                        if (phase_q && (idx_q != 3'd0))
                            rdata[{idx_q[1:0] - 2'd1, 3'b000} +: 8] <= i2c_rx_data;
                        state <= S_CHECK;
                    end
`ifdef I2C_SEQ_TIMEOUT_EN
                    else if (to_cnt == TO_LIMIT) begin
                        err_q <= ERR_TIMEOUT;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
`endif
                end
                S_CHECK: begin
                    if (i2c_tx_ready) begin
                        if (write_dir && ack_q) begin
                            err_q        <= (idx_q == 3'd0) ? ERR_ADDR_NACK : ERR_DATA_NACK;
                            i2c_cnd_stop <= 1'b1;
                            state        <= S_STOP;
                        end else if (idx_q == last_idx) begin
                            i2c_cnd_stop <= 1'b1;
                            state        <= S_STOP;
                        end else begin
                            idx_q         <= nb_idx;
                            i2c_tx_start  <= 1'b1;
                            i2c_cnd_start <= (nb_idx == 3'd0);
                            i2c_tx_data   <= byte_for(nb_ph, nb_idx);
                            i2c_rw        <= nb_rw;
                            i2c_tx_ack    <= nb_ack;
                            state         <= S_ISSUE;
                        end
                    end
                end
                S_STOP: begin
`ifdef I2C_SEQ_TIMEOUT_EN
                    to_cnt <= 16'd0;
`endif
                    state <= S_STOP_WAIT;
                end
                S_STOP_WAIT: begin
                    if (i2c_tx_ready) begin
                        if (go_phase_b) begin
                            phase_q       <= 1'b1;
                            idx_q         <= 3'd0;
                            i2c_tx_start  <= 1'b1;
                            i2c_cnd_start <= 1'b1;
                            i2c_tx_data   <= byte_for(nb_ph, nb_idx);
                            i2c_rw        <= nb_rw;
                            i2c_tx_ack    <= nb_ack;
                            state         <= S_ISSUE;
                        end else begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
`ifdef I2C_SEQ_TIMEOUT_EN
                    else if (to_cnt == TO_LIMIT) begin
                        err_q <= ERR_TIMEOUT;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
`endif
                end
                S_DONE: begin
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_reg_seq.sv
// Bench for i2c_reg_seq: handshake-level driver model with a behavioural slave.
`timescale 1ns/1ps
module tb_i2c_reg_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_read = 1'b0;
    logic [6:0]  cmd_dev = '0;
    logic [7:0]  cmd_reg = '0;
    logic [2:0]  cmd_len = '0;
    logic [31:0] cmd_wdata = '0;
    logic        done;
    logic [1:0]  err;
    logic [31:0] rdata;
    logic        i2c_cnd_start, i2c_cnd_stop, i2c_rw, i2c_tx_start, i2c_tx_ack;
    logic [7:0]  i2c_tx_data;
    logic        i2c_tx_ready;
    logic [7:0]  i2c_rx_data;
    logic        i2c_rx_ack;

    always #5 clk = ~clk;

    i2c_reg_seq #(.TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
        .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
        .done(done), .err(err), .rdata(rdata),
        .i2c_cnd_start(i2c_cnd_start), .i2c_cnd_stop(i2c_cnd_stop), .i2c_rw(i2c_rw),
        .i2c_tx_data(i2c_tx_data), .i2c_tx_start(i2c_tx_start), .i2c_tx_ack(i2c_tx_ack),
        .i2c_tx_ready(i2c_tx_ready), .i2c_rx_data(i2c_rx_data), .i2c_rx_ack(i2c_rx_ack)
    );

    // Slave configuration, set by the stimulus process only.
    logic [6:0]  slv_dev = 7'h3C;
    logic        slv_present = 1'b1;
    int          nack_at = 0;     // 1-based data byte index the slave NACKs, 0 = never
    logic        hang = 1'b0;     // driver never completes the current operation
    logic [7:0]  rmem [256];

    // Driver/slave model state, written only by the model process.
    logic        slv_addr, slv_first;
    logic [7:0]  slv_ptr;
    int          slv_wcnt, busy;
    logic [11:0] ev [128];        // {stop, start, rw, tx_ack(read), byte}
    int          n_ev = 0, n_txs = 0, n_cst = 0, n_stp = 0, n_proto = 0;
    logic        prv_rw, prv_ack, a;
    logic [7:0]  d;
    logic [11:0] evw;

    int n_checks = 0;
    int n_fail = 0;

    // Handshake-level driver with an embedded register-file slave.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i2c_tx_ready <= 1'b1;
            i2c_rx_data  <= 8'h00;
            i2c_rx_ack   <= 1'b1;
            busy = 0; slv_addr = 0; slv_first = 0; slv_ptr = 0; slv_wcnt = 0;
            prv_rw = 0; prv_ack = 1;
        end else begin
            if ((i2c_tx_start && i2c_cnd_stop) ||
                ((i2c_tx_start || i2c_cnd_stop) && !i2c_tx_ready) ||
                (i2c_cnd_start && !i2c_tx_start) ||
                (!i2c_tx_ready && (i2c_rw !== prv_rw || i2c_tx_ack !== prv_ack)))
                n_proto++;
            prv_rw = i2c_rw; prv_ack = i2c_tx_ack;
            if (i2c_cnd_start) n_cst++;
            if (i2c_tx_start) begin
                n_txs++;
                d = 8'hC3;
                if (i2c_cnd_start) begin
                    slv_addr = slv_present && (i2c_tx_data[7:1] == slv_dev);
                    slv_first = 1; a = !slv_addr;
                    evw = {1'b0, 1'b1, i2c_rw, 1'b0, i2c_tx_data};
                end else if (i2c_rw) begin
                    d = slv_addr ? rmem[slv_ptr] : 8'hFF;
                    slv_ptr++; a = 1'b1;
                    evw = {1'b0, 1'b0, 1'b1, i2c_tx_ack, d};
                end else begin
                    if (slv_addr && slv_first) begin
                        slv_ptr = i2c_tx_data; slv_first = 0; slv_wcnt = 0; a = 1'b0;
                    end else if (slv_addr) begin
                        slv_wcnt++; a = (slv_wcnt == nack_at); slv_ptr++;
                    end else a = 1'b1;
                    evw = {4'b0000, i2c_tx_data};
                end
                if (n_ev < 128) ev[n_ev] = evw;
                n_ev++;
                i2c_rx_ack <= a; i2c_rx_data <= d;
                busy = 3; i2c_tx_ready <= 1'b0;
            end else if (i2c_cnd_stop) begin
                n_stp++; slv_addr = 0;
                if (n_ev < 128) ev[n_ev] = 12'h800;
                n_ev++;
                busy = 3; i2c_tx_ready <= 1'b0;
            end else if (busy > 0) begin
                busy--;
                if (busy == 0 && !hang) i2c_tx_ready <= 1'b1;
            end
        end
    end

    task automatic send_cmd(input logic rd, input logic [6:0] dev, input logic [7:0] rg,
                            input logic [2:0] len, input logic [31:0] wd);
        @(negedge clk);
        cmd_read = rd; cmd_dev = dev; cmd_reg = rg; cmd_len = len; cmd_wdata = wd;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %0b want 1", cmd_ready); end
        n_checks++; if ({done, err, rdata} !== 35'd0) begin n_fail++; $display("FAIL reset_status: got done=%0b err=%0d rdata=%0h want 0", done, err, rdata); end
        n_checks++; if ({i2c_cnd_start, i2c_cnd_stop, i2c_rw, i2c_tx_data, i2c_tx_start, i2c_tx_ack} !== 13'b0000000000001)
            begin n_fail++; $display("FAIL reset_i2c: got %0h want 001", {i2c_cnd_start, i2c_cnd_stop, i2c_rw, i2c_tx_data, i2c_tx_start, i2c_tx_ack}); end
    endtask

    task automatic test_write;
        logic [11:0] exp [5];
        int base, b_txs, b_cst, b_stp, cyc;
        exp = '{12'h478, 12'h010, 12'h0EF, 12'h0BE, 12'h800};
        base = n_ev; b_txs = n_txs; b_cst = n_cst; b_stp = n_stp;
        send_cmd(1'b0, 7'h3C, 8'h10, 3'd2, 32'h0000BEEF);
        n_checks++; if ({i2c_tx_start, i2c_cnd_start, i2c_tx_data, cmd_ready} !== {2'b11, 8'h78, 1'b0})
            begin n_fail++; $display("FAIL wr_first_issue: got start=%0b cst=%0b data=%0h rdy=%0b want 1 1 78 0", i2c_tx_start, i2c_cnd_start, i2c_tx_data, cmd_ready); end
        wait_done(cyc);
        n_checks++; if (done !== 1'b1 || err !== 2'd0) begin n_fail++; $display("FAIL wr_done: got done=%0b err=%0d want 1 0", done, err); end
        n_checks++; if (n_ev - base !== 5) begin n_fail++; $display("FAIL wr_nev: got %0d want 5", n_ev - base); end
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (ev[base+i] !== exp[i]) begin n_fail++; $display("FAIL wr_ev%0d: got %0h want %0h", i, ev[base+i], exp[i]); end
        end
        n_checks++; if (n_cst - b_cst !== 1 || n_stp - b_stp !== 1 || n_txs - b_txs !== 4)
            begin n_fail++; $display("FAIL wr_pulses: got cst=%0d stp=%0d txs=%0d want 1 1 4", n_cst - b_cst, n_stp - b_stp, n_txs - b_txs); end
        @(negedge clk);
        n_checks++; if (cmd_ready !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL wr_ready_after: got rdy=%0b done=%0b want 1 0", cmd_ready, done); end
    endtask

    task automatic test_read;
        logic [11:0] exp [8];
        int base, cyc;
        exp = '{12'h4A0, 12'h002, 12'h800, 12'h4A1, 12'h211, 12'h222, 12'h333, 12'h800};
        slv_dev = 7'h50;
        rmem[2] = 8'h11; rmem[3] = 8'h22; rmem[4] = 8'h33;
        base = n_ev;
        send_cmd(1'b1, 7'h50, 8'h02, 3'd3, 32'hFFFFFFFF);
        wait_done(cyc);
        n_checks++; if (done !== 1'b1 || err !== 2'd0) begin n_fail++; $display("FAIL rd_done: got done=%0b err=%0d want 1 0", done, err); end
        n_checks++; if (rdata !== 32'h00332211) begin n_fail++; $display("FAIL rd_data: got %0h want 00332211", rdata); end
        n_checks++; if (n_ev - base !== 8) begin n_fail++; $display("FAIL rd_nev: got %0d want 8", n_ev - base); end
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (ev[base+i] !== exp[i]) begin n_fail++; $display("FAIL rd_ev%0d: got %0h want %0h", i, ev[base+i], exp[i]); end
        end
        repeat (5) @(negedge clk);
        n_checks++; if (rdata !== 32'h00332211 || err !== 2'd0) begin n_fail++; $display("FAIL rd_hold: got %0h err=%0d want 00332211 0", rdata, err); end
    endtask

    task automatic test_read_len0;
        logic [11:0] exp [3];
        int base, b_txs, cyc;
        exp = '{12'h4A0, 12'h005, 12'h800};
        base = n_ev; b_txs = n_txs;
        send_cmd(1'b1, 7'h50, 8'h05, 3'd0, 32'h0);
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL rd0_clear: got %0h want 0", rdata); end
        repeat (4) @(negedge clk);
        cmd_read = 1'b0; cmd_dev = 7'h3C; cmd_reg = 8'h77; cmd_len = 3'd4; cmd_valid = 1'b1;
        repeat (3) @(negedge clk);
        cmd_valid = 1'b0;
        wait_done(cyc);
        n_checks++; if (done !== 1'b1 || err !== 2'd0 || rdata !== 32'h0)
            begin n_fail++; $display("FAIL rd0_done: got done=%0b err=%0d rdata=%0h want 1 0 0", done, err, rdata); end
        repeat (20) @(negedge clk);
        n_checks++; if (n_ev - base !== 3 || n_txs - b_txs !== 2) begin n_fail++; $display("FAIL rd0_nev: got ev=%0d txs=%0d want 3 2", n_ev - base, n_txs - b_txs); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (ev[base+i] !== exp[i]) begin n_fail++; $display("FAIL rd0_ev%0d: got %0h want %0h", i, ev[base+i], exp[i]); end
        end
    endtask

    task automatic test_addr_nack;
        int base, b_txs, cyc;
        slv_present = 1'b0;
        base = n_ev; b_txs = n_txs;
        send_cmd(1'b0, 7'h20, 8'h01, 3'd2, 32'h1234);
        wait_done(cyc);
        n_checks++; if (done !== 1'b1 || err !== 2'd1) begin n_fail++; $display("FAIL anack_err: got done=%0b err=%0d want 1 1", done, err); end
        repeat (20) @(negedge clk);
        n_checks++; if (n_ev - base !== 2 || ev[base] !== 12'h440 || ev[base+1] !== 12'h800 || n_txs - b_txs !== 1)
            begin n_fail++; $display("FAIL anack_seq: got n=%0d %0h %0h txs=%0d want 2 440 800 1", n_ev - base, ev[base], ev[base+1], n_txs - b_txs); end
        slv_present = 1'b1;
    endtask

    task automatic test_data_nack;
        logic [11:0] exp [5];
        int base, cyc;
        exp = '{12'h478, 12'h020, 12'h0AA, 12'h0BB, 12'h800};
        slv_dev = 7'h3C; nack_at = 2;
        base = n_ev;
        send_cmd(1'b0, 7'h3C, 8'h20, 3'd3, 32'h00CCBBAA);
        wait_done(cyc);
        n_checks++; if (done !== 1'b1 || err !== 2'd2) begin n_fail++; $display("FAIL dnack_err: got done=%0b err=%0d want 1 2", done, err); end
        n_checks++; if (n_ev - base !== 5) begin n_fail++; $display("FAIL dnack_nev: got %0d want 5", n_ev - base); end
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (ev[base+i] !== exp[i]) begin n_fail++; $display("FAIL dnack_ev%0d: got %0h want %0h", i, ev[base+i], exp[i]); end
        end
        nack_at = 0;
    endtask

    task automatic test_back_to_back;
        logic [11:0] exp [11];
        int base, cyc;
        exp = '{12'h478, 12'h001, 12'h05A, 12'h800,
                12'h478, 12'h002, 12'h011, 12'h022, 12'h033, 12'h044, 12'h800};
        base = n_ev;
        send_cmd(1'b0, 7'h3C, 8'h01, 3'd1, 32'h0000005A);
        wait_done(cyc);
        n_checks++; if (done !== 1'b1 || err !== 2'd0) begin n_fail++; $display("FAIL b2b_done1: got done=%0b err=%0d want 1 0", done, err); end
        send_cmd(1'b0, 7'h3C, 8'h02, 3'd5, 32'h44332211);
        wait_done(cyc);
        n_checks++; if (done !== 1'b1 || err !== 2'd0) begin n_fail++; $display("FAIL b2b_done2: got done=%0b err=%0d want 1 0", done, err); end
        n_checks++; if (n_ev - base !== 11) begin n_fail++; $display("FAIL b2b_nev: got %0d want 11", n_ev - base); end
        for (int i = 0; i < 11; i++) begin
            n_checks++; if (ev[base+i] !== exp[i]) begin n_fail++; $display("FAIL b2b_ev%0d: got %0h want %0h", i, ev[base+i], exp[i]); end
        end
    endtask

    task automatic test_reset_mid_write;
        int b_stp;
        b_stp = n_stp;
        send_cmd(1'b0, 7'h3C, 8'h10, 3'd2, 32'h0000BEEF);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (cmd_ready !== 1'b1 || {done, err, rdata} !== 35'd0)
            begin n_fail++; $display("FAIL rstmid_status: got rdy=%0b done=%0b err=%0d rdata=%0h want 1 0 0 0", cmd_ready, done, err, rdata); end
        n_checks++; if ({i2c_cnd_start, i2c_cnd_stop, i2c_rw, i2c_tx_data, i2c_tx_start, i2c_tx_ack} !== 13'b0000000000001)
            begin n_fail++; $display("FAIL rstmid_i2c: got %0h want 001", {i2c_cnd_start, i2c_cnd_stop, i2c_rw, i2c_tx_data, i2c_tx_start, i2c_tx_ack}); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_checks++; if (n_stp !== b_stp) begin n_fail++; $display("FAIL rstmid_nostop: got %0d stops want 0", n_stp - b_stp); end
    endtask

`ifdef I2C_SEQ_TIMEOUT_EN
    task automatic test_timeout;
        int b_stp, cyc;
        b_stp = n_stp;
        hang = 1'b1;
        send_cmd(1'b0, 7'h3C, 8'h10, 3'd1, 32'h1);
        wait_done(cyc);
        n_checks++; if (done !== 1'b1 || err !== 2'd3) begin n_fail++; $display("FAIL to_err: got done=%0b err=%0d want 1 3", done, err); end
        n_checks++; if (cyc !== 101) begin n_fail++; $display("FAIL to_cycles: got %0d want 101", cyc); end
        n_checks++; if (n_stp !== b_stp) begin n_fail++; $display("FAIL to_nostop: got %0d stops want 0", n_stp - b_stp); end
        @(negedge clk);
        rst_n = 1'b0; hang = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_write();
        test_read();
        test_read_len0();
        test_addr_nack();
        test_data_nack();
        test_back_to_back();
        test_reset_mid_write();
`ifdef I2C_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        test_write();
        n_checks++; if (n_proto !== 0) begin n_fail++; $display("FAIL protocol: got %0d violations want 0", n_proto); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_reg_seq.md
Name: i2c_reg_seq

Overview:
- Transaction sequencer in front of the byte-level I2C driver.
- Accepts one register-level command (device address, register index, 0-4 data bytes, read or write).
- Issues the byte/condition handshakes that command needs, and returns read data plus a status code.
- Sits between the CPU I/O register file and the I2C driver. Software issues one command instead of hand-stepping start, byte and stop.

Parameters:
TIMEOUT_CYCLES, 65535, watchdog limit per driver operation (used only with I2C_SEQ_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command request
cmd_ready  out  1  high only in S_IDLE
cmd_read  in  1  1=register read, 0=register write
cmd_dev  in  7  7-bit device address
cmd_reg  in  8  register index
cmd_len  in  3  data byte count, 0..4 (values 5..7 treated as 4)
cmd_wdata  in  32  write bytes, byte0 = [7:0], sent first
done  out  1  one-cycle pulse at command end
err  out  2  0=OK, 1=address NACK, 2=data/register NACK, 3=timeout
rdata  out  32  read bytes, byte0 in [7:0], unread bytes 0
i2c_cnd_start  out  1  to driver cnd_start
i2c_cnd_stop  out  1  to driver cnd_stop
i2c_rw  out  1  to driver rw
i2c_tx_data  out  8  to driver tx_data
i2c_tx_start  out  1  to driver tx_start
i2c_tx_ack  out  1  to driver tx_ack (0=ACK, 1=NACK)
i2c_tx_ready  in  1  from driver tx_ready
i2c_rx_data  in  8  from driver rx_data
i2c_rx_ack  in  1  from driver rx_ack (0=ACK)

Behaviour:
- Reset values:
  - cmd_ready=1, done=0, err=0, rdata=0.
  - All i2c_* outputs 0, except i2c_tx_ack=1.
  - State S_IDLE, byte index 0.
- Reset mid-transaction aborts immediately with no stop. The driver shares the reset.
- Command accept:
  - Accept on cmd_valid & cmd_ready. All cmd_* fields are latched.
  - rdata clears to 0 at accept.
  - cmd_valid while busy is ignored.
- Driver protocol:
  - i2c_tx_start and i2c_cnd_stop are single-cycle pulses.
  - Either is issued only when i2c_tx_ready=1 and never in the same cycle as the other.
  - i2c_cnd_stop is never held as a level, because the driver stays busy while it is high.
  - i2c_cnd_start is high only in the tx_start cycle of a first (address) byte.
  - i2c_rw and i2c_tx_ack change only while i2c_tx_ready=1, and are held for the whole byte.
- Byte completion:
  - After a tx_start or cnd_stop pulse, state S_WAIT waits for i2c_tx_ready=1.
  - The cycle after the pulse always reads 0.
  - On completion, i2c_rx_ack and i2c_rx_data are sampled in that same cycle.
- Stop: every transaction ends, including on error, with a cnd_stop pulse issued from the driver's NEXT state (tx_ready=1), then S_STOP_WAIT waits for tx_ready=1.
- Write command sequence, all with rw=0:
  - {dev,0} with start.
  - reg.
  - cmd_len bytes of cmd_wdata, LSB byte first.
  - stop.
  - cmd_len=0 is a pointer-only write.
- Read command sequence:
  - Phase A, rw=0: {dev,0} with start, then reg, then stop.
  - Phase B, address byte with rw=0: {dev,1} with start.
  - Phase B, data bytes with rw=1: cmd_len bytes, i2c_tx_ack=0 except 1 on the last byte.
  - Byte k of the read lands in rdata[8k+7:8k].
  - Phase B ends with stop.
  - cmd_len=0 on a read runs phase A only.
- NACK handling:
  - A NACK (rx_ack=1) on a write-direction byte skips all remaining bytes and goes to stop.
  - err=1 if the NACK was on an address byte, 2 otherwise.
  - rx_ack is ignored on read-data bytes.
- FSM: S_IDLE -> S_ISSUE (one cycle, pulse) -> S_WAIT -> S_CHECK -> {S_ISSUE | S_STOP} -> S_STOP_WAIT -> {S_ISSUE for phase B | S_DONE} -> S_IDLE.
- Completion:
  - S_DONE asserts done for one cycle.
  - err and rdata are valid that cycle and held until the next accept.
  - First tx_start occurs 1 cycle after accept.
  - cmd_ready rises the cycle after done.

Optional Feature:
- Macro: I2C_SEQ_TIMEOUT_EN.
- With it defined:
  - A 16-bit counter runs in S_WAIT and S_STOP_WAIT and clears on each new pulse.
  - Reaching TIMEOUT_CYCLES sets err=3 and goes straight to S_DONE with no stop issued.
- Without it: no counter exists, waits are unbounded, and err is never 3.

Decomposition:
- Package i2c_seq_pkg holds:
  - enum state_t: S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_STOP, S_STOP_WAIT, S_DONE.
  - enum err_t: ERR_OK, ERR_ADDR_NACK, ERR_DATA_NACK, ERR_TIMEOUT.
  - localparam MAX_LEN=4.
- No sub-module: single flat FSM.
- The bench pairs it with the existing I2C driver plus a behavioural I2C slave model.

Test Plan:
1. Write dev=0x3C reg=0x10 len=2 wdata=0x0000BEEF, slave ACKs all -> bytes 0x78,0x10,0xEF,0xBE on SDA, one stop; done with err=0; exactly one cnd_start pulse and one cnd_stop pulse.
2. Read dev=0x50 reg=0x02 len=3, slave returns 0x11,0x22,0x33 -> bytes 0xA0,0x02, stop, start, 0xA1; master ACK,ACK,NACK; rdata=0x00332211, err=0.
3. Write dev=0x20 with no device present -> address NACK, stop issued, done with err=1, no further tx_start.
4. Write len=3 with slave NACK on 2nd data byte -> 3rd byte not sent, stop, err=2.
5. Read len=0 reg=0x05 -> phase A only (0xA0,0x05, stop), done, rdata=0; cmd_valid pulsed mid-transaction is ignored.
6. (I2C_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=100) tie i2c_tx_ready low after the first tx_start -> done with err=3 exactly 100 cycles into S_WAIT; assert rst_n low mid-write -> all outputs return to reset values asynchronously.
